spmv_mem_responder: RTL and testbench
=====================================

Name: spmv_mem_responder

Overview:
- Memory-side responder for the PE memory port: accepts the PE's ld/st request stream and returns tagged load responses.
- Backed by an internal 64-bit word RAM, with a fixed-latency read pipeline and an in-order response FIFO.
- Drives the request-side stall and honours the response-side stall.
- Serves as the memory endpoint for PE-level simulation and as the on-chip scratch responder.

Parameters:
ADDR_BITS, 10, log2 of RAM depth in 64-bit words
LATENCY, 4, load pipeline depth in cycles from accept to FIFO write (min 1)
FIFO_DEPTH, 16, response FIFO entries; also max outstanding loads
ALMOST_FULL_COUNT, 4, free-slot margin at which req_mem_stall asserts (covers requester skid)
LFSR_SEED, 16'hACE1, seed for the optional stall jitter

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_mem_ld  in  1  load request strobe
req_mem_st  in  1  store request strobe
req_mem_addr  in  48  byte address
req_mem_d_or_tag  in  64  store data, or load tag in bits [2:0]
req_mem_stall  out  1  registered backpressure to requester
rsp_mem_push  out  1  load response valid
rsp_mem_tag  out  3  tag echoed from the load request
rsp_mem_q  out  64  load data
rsp_mem_stall  in  1  requester cannot take responses
busy  out  1  outstanding loads != 0
overflow  out  1  sticky: load dropped for lack of capacity
proto_err  out  1  sticky: ld and st in the same cycle

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0.
  - Pipeline valids cleared, FIFO emptied, outstanding counter 0, sticky flags cleared, LFSR reloaded to LFSR_SEED.
  - RAM contents are not reset.
  - Reset mid-operation silently discards in-flight loads.
- Addressing: word index = req_mem_addr[ADDR_BITS+2:3]; bits [2:0] and bits above ADDR_BITS+2 are ignored (aliasing).
- Store:
  - Written to RAM in the accept cycle; no response.
  - A load accepted in any later cycle returns the new data.
- Load:
  - RAM read in the accept cycle; {tag, data} travels LATENCY stages, then is written to the FIFO.
  - Responses are strictly in acceptance order.
- Simultaneous ld and st: the store is performed, the load is ignored, proto_err is set.
- Outstanding counter (width clog2(FIFO_DEPTH)+1) counts pipeline entries plus FIFO entries:
  - +1 on an accepted load, -1 on a FIFO pop; both in the same cycle leaves it unchanged.
  - A load arriving when outstanding == FIFO_DEPTH is dropped and overflow is set; otherwise loads are always accepted, even while req_mem_stall is high.
- req_mem_stall: registered; next value is outstanding >= FIFO_DEPTH - ALMOST_FULL_COUNT.
- Response pop:
  - Pop when FIFO not empty and rsp_mem_stall == 0 (and jitter allows).
  - rsp_mem_push, rsp_mem_tag and rsp_mem_q are registered and valid the cycle after the pop; rsp_mem_push is low otherwise.
  - rsp_mem_tag and rsp_mem_q hold their last values when push is low.
- Latency: with an empty FIFO and no stall, rsp_mem_push is high exactly LATENCY+1 cycles after the load accept cycle.
- Throughput: one load accepted and one response per cycle sustained.
- rsp_mem_stall high: the FIFO fills; the pipeline keeps draining into reserved slots, so the FIFO can never overflow.
- busy: combinational from outstanding != 0.

Optional Feature:
- Macro: SPMV_MEM_RSP_JITTER_EN
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) steps every cycle.
  - A pop is additionally suppressed on cycles where lfsr[1:0] == 2'b00, injecting pseudo-random response bubbles.
  - Ordering and data are unchanged.
- Undefined: no LFSR; pops occur on every eligible cycle.

Test Plan:
- Store 64'h1122334455667788 at addr 0x40, then load addr 0x40 with tag 3 -> one rsp_mem_push, tag 3, q 64'h1122334455667788, exactly LATENCY+1 cycles after the load.
- 8 back-to-back loads of addrs 0x0..0x38 (tags 0..7, RAM preloaded with word index i = i*3) -> 8 consecutive pushes, tags 0..7 in order, q = 0,3,...,21.
- Hold rsp_mem_stall=1 and issue 16 loads -> req_mem_stall rises one cycle after outstanding reaches 12; a 17th load sets overflow=1. Release stall -> exactly 16 responses, in order.
- Assert ld and st together (addr 0x8, data 5) -> word 1 = 5, no response, proto_err=1.
- Assert rst while 3 loads are in flight -> outputs 0 immediately; no responses after release; busy=0.
- With SPMV_MEM_RSP_JITTER_EN, 64 loads with rsp_mem_stall=0 -> all 64 responses arrive in order with correct data; total cycles > 64 + LATENCY + 1.

Source files
------------

// File: rtl/spmv_mem_responder_if.sv
// PE memory port bundle: load/store request stream towards memory and tagged load responses back.
// Handshake: a request strobe is consumed in the cycle it is high, and req_mem_stall is only advisory.
// rsp_mem_push is a one-cycle valid that the responder raises only after a cycle where rsp_mem_stall was low.
interface spmv_mem_responder_if;
  logic        req_mem_ld;
  logic        req_mem_st;
  logic [47:0] req_mem_addr;
  logic [63:0] req_mem_d_or_tag;
  logic        req_mem_stall;
  logic        rsp_mem_push;
  logic [2:0]  rsp_mem_tag;
  logic [63:0] rsp_mem_q;
  logic        rsp_mem_stall;

  modport master (
    output req_mem_ld, req_mem_st, req_mem_addr, req_mem_d_or_tag, rsp_mem_stall,
    input  req_mem_stall, rsp_mem_push, rsp_mem_tag, rsp_mem_q
  );

  modport slave (
    input  req_mem_ld, req_mem_st, req_mem_addr, req_mem_d_or_tag, rsp_mem_stall,
    output req_mem_stall, rsp_mem_push, rsp_mem_tag, rsp_mem_q
  );
endinterface

// File: rtl/spmv_mem_responder.sv
// Memory-side responder: 64-bit word RAM, fixed-latency load pipeline, in-order response FIFO.
// Define SPMV_MEM_RSP_JITTER_EN to inject LFSR-driven response bubbles.
module spmv_mem_responder #(
  parameter int          ADDR_BITS         = 10,
  parameter int          LATENCY           = 4,
  parameter int          FIFO_DEPTH        = 16,
  parameter int          ALMOST_FULL_COUNT = 4,
  parameter logic [15:0] LFSR_SEED         = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst,
  spmv_mem_responder_if.slave  mem,
  output logic                 busy,
  output logic                 overflow,
  output logic                 proto_err
);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int WORDS = 1 << ADDR_BITS;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(FIFO_DEPTH - ALMOST_FULL_COUNT);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

  typedef struct packed {
    logic        v;
    logic [2:0]  tag;
    logic [63:0] data;
  } ent_t;

  logic [63:0]          ram [WORDS];
  logic [66:0]          fifo_mem [FIFO_DEPTH];
  logic [ADDR_BITS-1:0] widx;
  logic                 ld_req, st_req, ld_acc, pop, jitter_ok;
  ent_t                 s0, fifo_in;
  logic [66:0]          head;

  logic [CW-1:0] out_q, out_d, fcnt_q, fcnt_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic          stall_q, stall_d, push_q, push_d, ovf_q, ovf_d, perr_q, perr_d;
  logic [2:0]    tag_q, tag_d;
  logic [63:0]   dat_q, dat_d;

  logic unused_addr;
  assign unused_addr = ^{mem.req_mem_addr[47:ADDR_BITS+3], mem.req_mem_addr[2:0]};

  assign widx   = mem.req_mem_addr[ADDR_BITS+2:3];
  assign st_req = mem.req_mem_st;
  // A simultaneous ld+st is treated as a store only.
  assign ld_req = mem.req_mem_ld & ~mem.req_mem_st;
  assign ld_acc = ld_req & (out_q != FULL_CNT);

  always_ff @(posedge clk) begin
    if (st_req) ram[widx] <= mem.req_mem_d_or_tag;
  end

  // The accept cycle counts as the first latency stage, so LATENCY-1 registers follow it.
  assign s0 = '{v: ld_acc, tag: mem.req_mem_d_or_tag[2:0], data: ram[widx]};

  generate
    if (LATENCY == 1) begin : g_lat1
      assign fifo_in = s0;
    end else begin : g_pipe
      ent_t pipe_q [LATENCY-1];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < LATENCY - 1; k++) pipe_q[k] <= '0;
        end else begin
          pipe_q[0] <= s0;
          for (int k = 1; k < LATENCY - 1; k++) pipe_q[k] <= pipe_q[k-1];
        end
      end
      assign fifo_in = pipe_q[LATENCY-2];
    end
  endgenerate

`ifdef SPMV_MEM_RSP_JITTER_EN
  logic [15:0] lfsr_q, lfsr_d;
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end
  assign jitter_ok = (lfsr_q[1:0] != 2'b00);
`else
  logic unused_seed;
  assign unused_seed = ^LFSR_SEED;
  assign jitter_ok   = 1'b1;
`endif

  // Every in-flight load already owns a FIFO slot via out_q, so writes never need a full check.
  always_ff @(posedge clk) begin
    if (fifo_in.v) fifo_mem[wr_q] <= {fifo_in.tag, fifo_in.data};
  end

  assign head = fifo_mem[rd_q];
  assign pop  = (fcnt_q != '0) & ~mem.rsp_mem_stall & jitter_ok;

  always_comb begin
    out_d   = out_q;
    fcnt_d  = fcnt_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    tag_d   = tag_q;
    dat_d   = dat_q;
    push_d  = pop;
    stall_d = (out_q >= AF_CNT);
    ovf_d   = ovf_q | (ld_req & (out_q == FULL_CNT));
    perr_d  = perr_q | (mem.req_mem_ld & mem.req_mem_st);
    case ({ld_acc, pop})
      2'b10:   out_d = out_q + 1'b1;
      2'b01:   out_d = out_q - 1'b1;
      default: out_d = out_q;
    endcase
    case ({fifo_in.v, pop})
      2'b10:   fcnt_d = fcnt_q + 1'b1;
      2'b01:   fcnt_d = fcnt_q - 1'b1;
      default: fcnt_d = fcnt_q;
    endcase
    if (fifo_in.v) wr_d = (wr_q == LAST_PTR) ? '0 : wr_q + 1'b1;
    if (pop) begin
      rd_d  = (rd_q == LAST_PTR) ? '0 : rd_q + 1'b1;
      tag_d = head[66:64];
      dat_d = head[63:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= '0;
      fcnt_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      stall_q <= 1'b0;
      push_q  <= 1'b0;
      tag_q   <= '0;
      dat_q   <= '0;
      ovf_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      out_q   <= out_d;
      fcnt_q  <= fcnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      stall_q <= stall_d;
      push_q  <= push_d;
      tag_q   <= tag_d;
      dat_q   <= dat_d;
      ovf_q   <= ovf_d;
      perr_q  <= perr_d;
    end
  end

  assign mem.req_mem_stall = stall_q;
  assign mem.rsp_mem_push  = push_q;
  assign mem.rsp_mem_tag   = tag_q;
  assign mem.rsp_mem_q     = dat_q;
  assign busy              = (out_q != '0);
  assign overflow          = ovf_q;
  assign proto_err         = perr_q;
endmodule

// File: tb/tb_spmv_mem_responder.sv
// Directed bench for spmv_mem_responder: store/load, streaming, backpressure, overflow, ld+st conflict, reset.
module tb_spmv_mem_responder;
  localparam int LATENCY    = 4;
  localparam int FIFO_DEPTH = 16;
  localparam int AF_COUNT   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, overflow, proto_err;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [66:0] exp_q[$];
  int          push_cyc_q[$];

  spmv_mem_responder_if bus();

  spmv_mem_responder #(
    .ADDR_BITS(10), .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH),
    .ALMOST_FULL_COUNT(AF_COUNT), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst), .mem(bus.slave),
    .busy(busy), .overflow(overflow), .proto_err(proto_err)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL global_timeout: got cycle %0d required finish", cyc);
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [66:0] obs, input logic [66:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every response must match the head of exp_q
  always @(negedge clk) begin
    if (!rst && bus.rsp_mem_push) begin
      push_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) check_eq("rsp_unexpected", bus.rsp_mem_push, 1'b0);
      else                   check_eq("rsp_tag_data", {bus.rsp_mem_tag, bus.rsp_mem_q}, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic drive(input logic ld, input logic st, input logic [47:0] addr, input logic [63:0] d);
    bus.req_mem_ld       = ld;
    bus.req_mem_st       = st;
    bus.req_mem_addr     = addr;
    bus.req_mem_d_or_tag = d;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.req_mem_ld = 1'b0;
    bus.req_mem_st = 1'b0;
  endtask

  task automatic load(input logic [47:0] addr, input logic [2:0] tag, input logic [63:0] exp_data);
    exp_q.push_back({tag, exp_data});
    drive(1'b1, 1'b0, addr, {61'd0, tag});
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_rsp(input string tag, input int n, input int budget);
    int i = 0;
    while (push_cyc_q.size() < n && i < budget) begin
      @(posedge clk); #1;
      i++;
    end
    check_eq(tag, push_cyc_q.size(), n);
  endtask

  function automatic logic [63:0] word_val(input int w);
    return (w == 1) ? 64'd5 : 64'(w * 3);
  endfunction

  initial begin
    int issue;
    int start;
    bus.req_mem_ld = 1'b0; bus.req_mem_st = 1'b0;
    bus.req_mem_addr = '0; bus.req_mem_d_or_tag = '0;
    bus.rsp_mem_stall = 1'b0;
    wait_cycles(2);

    check_eq("rst_req_stall", bus.req_mem_stall, 1'b0);
    check_eq("rst_push", bus.rsp_mem_push, 1'b0);
    check_eq("rst_tag", bus.rsp_mem_tag, 3'd0);
    check_eq("rst_q", bus.rsp_mem_q, 64'd0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_overflow", overflow, 1'b0);
    check_eq("rst_proto_err", proto_err, 1'b0);
    rst = 1'b0;
    wait_cycles(1);

    // store then load, latency LATENCY+1
    drive(1'b0, 1'b1, 48'h40, 64'h1122334455667788);
    push_cyc_q.delete();
    issue = cyc;
    load(48'h40, 3'd3, 64'h1122334455667788);
    idle();
    wait_rsp("t1_wait", 1, 20);
    if (push_cyc_q.size() >= 1) check_eq("t1_latency", push_cyc_q[0] - issue, LATENCY + 1);
    wait_cycles(5);
    check_eq("t1_single_rsp", push_cyc_q.size(), 1);

    // preload word i = i*3, then 8 back-to-back loads
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 48'(i * 8), 64'(i * 3));
    idle();
    push_cyc_q.delete();
    for (int i = 0; i < 8; i++) load(48'(i * 8), 3'(i), 64'(i * 3));
    idle();
    wait_rsp("t2_wait", 8, 40);
    if (push_cyc_q.size() >= 8) check_eq("t2_back2back", push_cyc_q[7] - push_cyc_q[0], 7);
    check_eq("t2_drained", exp_q.size(), 0);

    // response stall: fill to capacity, watch req_mem_stall, overflow on the 17th
    bus.rsp_mem_stall = 1'b1;
    push_cyc_q.delete();
    for (int k = 0; k < 16; k++) begin
      check_eq("t3_req_stall", bus.req_mem_stall, (k >= 13));
      load(48'((k % 8) * 8), 3'(k % 8), 64'((k % 8) * 3));
    end
    check_eq("t3_overflow_pre", overflow, 1'b0);
    drive(1'b1, 1'b0, 48'h0, 64'd7);
    idle();
    check_eq("t3_overflow", overflow, 1'b1);
    check_eq("t3_busy", busy, 1'b1);
    wait_cycles(6);
    check_eq("t3_held", push_cyc_q.size(), 0);
    check_eq("t3_req_stall_full", bus.req_mem_stall, 1'b1);
    bus.rsp_mem_stall = 1'b0;
    wait_rsp("t3_wait", 16, 60);
    wait_cycles(8);
    check_eq("t3_count", push_cyc_q.size(), 16);
    check_eq("t3_drained", exp_q.size(), 0);
    check_eq("t3_busy_idle", busy, 1'b0);
    check_eq("t3_req_stall_idle", bus.req_mem_stall, 1'b0);

    // ld and st together: store wins, no response
    check_eq("t4_proto_pre", proto_err, 1'b0);
    drive(1'b1, 1'b1, 48'h8, 64'd5);
    idle();
    check_eq("t4_proto_err", proto_err, 1'b1);
    push_cyc_q.delete();
    load(48'h8, 3'd2, 64'd5);
    idle();
    wait_rsp("t4_wait", 1, 20);
    wait_cycles(6);
    check_eq("t4_single_rsp", push_cyc_q.size(), 1);

    // reset with loads in flight
    push_cyc_q.delete();
    for (int i = 2; i < 5; i++) load(48'(i * 8), 3'(i), word_val(i));
    idle();
    rst = 1'b1;
    #1;
    exp_q.delete();
    check_eq("t5_push", bus.rsp_mem_push, 1'b0);
    check_eq("t5_tag", bus.rsp_mem_tag, 3'd0);
    check_eq("t5_q", bus.rsp_mem_q, 64'd0);
    check_eq("t5_busy", busy, 1'b0);
    check_eq("t5_overflow", overflow, 1'b0);
    check_eq("t5_proto_err", proto_err, 1'b0);
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(15);
    check_eq("t5_no_rsp", push_cyc_q.size(), 0);
    check_eq("t5_busy_after", busy, 1'b0);

`ifdef SPMV_MEM_RSP_JITTER_EN
    begin
      int n = 0;
      int guard = 0;
      push_cyc_q.delete();
      start = cyc;
      while (n < 64 && guard < 2000) begin
        if (!bus.req_mem_stall) begin
          load(48'((n % 8) * 8), 3'(n % 8), word_val(n % 8));
          n++;
        end else begin
          idle();
          wait_cycles(1);
        end
        guard++;
      end
      idle();
      wait_rsp("jit_wait", 64, 600);
      if (push_cyc_q.size() >= 64)
        check_eq("jit_bubbles", (push_cyc_q[63] - start) > (64 + LATENCY + 1), 1'b1);
      check_eq("jit_drained", exp_q.size(), 0);
    end
`else
    start = cyc;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
